jump_instr_encoder: RTL and testbench
=====================================

// Module: jump_instr_encoder
// PURPOSE
//  Inverse of the jump-address path: packs a jump target address back into a
//  MIPS J-type word (J or JAL) relative to the jump's own PC. Used by the
//  program loader/trap-vector patcher to emit jump instructions into imem.
//  2-stage valid/ready pipeline, 1 word/cycle throughput, flags unencodable targets.
// PARAMETERS
//  OPCODE_J    6'b000010  opcode emitted when in_link=0
//  OPCODE_JAL  6'b000011  opcode emitted when in_link=1
//  ERR_CNT_W   8          width of saturating error counter
// PORTS
//  clk             in   1          rising-edge clock
//  rst_n           in   1          synchronous reset, active low
//  in_valid        in   1          request valid
//  in_ready        out  1          encoder can accept request this cycle
//  in_link         in   1          1 = JAL, 0 = J
//  in_pc           in   32         address of the jump instruction itself
//  in_target       in   32         desired jump target address
//  out_valid       out  1          encoded word valid
//  out_ready       in   1          consumer accepts word this cycle
//  out_instr       out  32         {opcode, target[27:2]}
//  out_err_align   out  1          target[1:0] != 0
//  out_err_region  out  1          target[31:28] != (pc+4)[31:28]
//  err_count       out  ERR_CNT_W  saturating count of erroneous words delivered
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): s1/s2 valids=0, out_instr=0, both err flags=0,
//   err_count=0; in-flight words discarded, none emitted after reset.
//  Stage 1 (S1) register: accepts on in_valid && in_ready; computes
//   pc4 = in_pc + 32'd4 (mod 2^32, wraps 0xFFFF_FFFC -> 0), region and align
//   checks, index = in_target[27:2], opcode select.
//  Stage 2 (S2) = output register; out_* driven directly from flops.
//  Advance: s2_free = !s2_valid || out_ready; S1->S2 when s1_valid && s2_free.
//   in_ready = !s1_valid || s2_free (combinational, no in_valid dependency).
//  Latency: word accepted in cycle N is out_valid in cycle N+2 if no stall.
//  Stall: while out_valid && !out_ready, out_instr/err flags held stable;
//   max 2 words buffered; order preserved; no drop, no duplicate.
//  Errors do not suppress output: word still encoded from target[27:2];
//   both flags may be set simultaneously.
//  err_count: +1 on out_valid && out_ready && (err_align || err_region);
//   saturates at 2^ERR_CNT_W-1, never wraps.
//  Round-trip: with no errors, {pc4[31:28], out_instr[25:0], 2'b00} == in_target.
//  Simultaneous in accept + out handoff in same cycle: both occur, full rate.
// TESTING
//  1. pc=0x0040_0000, tgt=0x0040_0100, link=0 -> out_instr=0x0810_0040, no
//     errs, out_valid exactly 2 cycles after accept.
//  2. Same, link=1 -> out_instr=0x0C10_0040; 4 back-to-back with out_ready=1
//     -> 4 words on 4 consecutive cycles, in_ready stays 1.
//  3. pc=0x0FFF_FFFC, tgt=0x0FFF_0000 -> err_region=1, out_instr=0x0BFF_C000,
//     err_count=1; pc=0xFFFF_FFFC, tgt=0x0000_0040 -> no err (pc4 wraps to 0).
//  4. tgt=0x0040_0102 -> err_align=1, err_region=0, out_instr=0x0810_0040.
//  5. out_ready=0 for 5 cycles while streaming 3 words -> in_ready=0 after 2
//     accepted, out_instr stable; release -> 3 words in order, none lost.
//  6. ERR_CNT_W=2, 5 erroneous words -> err_count=3; rst_n=0 one cycle with
//     2 words in flight -> all outputs 0 next cycle, no stale word emitted.

Source files
------------

// File: rtl/jump_instr_encoder.sv
// jump_instr_encoder
//   Packs a jump target address into a MIPS J-type word (J or JAL) relative
//   to the jump's own PC. Two-stage valid/ready pipeline, one word per cycle,
//   unencodable targets flagged (the word is still emitted).
//
// Ports
//   clk, rst_n       rising-edge clock, synchronous active-low reset
//   in_valid/ready   request handshake (in_ready independent of in_valid)
//   in_link          1 = JAL, 0 = J
//   in_pc            address of the jump instruction itself
//   in_target        desired jump target address
//   out_valid/ready  result handshake
//   out_instr        {opcode, target[27:2]}
//   out_err_align    target[1:0] != 0
//   out_err_region   target[31:28] != (pc+4)[31:28]
//   err_count        saturating count of erroneous words delivered
module jump_instr_encoder #(
  parameter logic [5:0]  OPCODE_J   = 6'b000010,
  parameter logic [5:0]  OPCODE_JAL = 6'b000011,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_link,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err_align,
  output logic                 out_err_region,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Stage-1 encode (combinational, registered into S1)
  logic [31:0] pc4;
  logic [31:0] instr_d;
  logic        align_err_d;
  logic        region_err_d;

  always_comb begin
    pc4          = in_pc + 32'd4;          // wraps modulo 2^32
    align_err_d  = |in_target[1:0];
    region_err_d = (in_target[31:28] != pc4[31:28]);
    instr_d      = {(in_link ? OPCODE_JAL : OPCODE_J), in_target[27:2]};
  end

  // Stage-1 register
  logic        s1_valid;
  logic [31:0] s1_instr;
  logic        s1_err_align;
  logic        s1_err_region;

  // Handshake / advance control
  logic s2_free;
  logic in_accept;
  logic s1_adv;
  logic out_fire;

  assign s2_free   = !out_valid || out_ready;
  assign in_ready  = !s1_valid || s2_free;
  assign in_accept = in_valid && in_ready;
  assign s1_adv    = s1_valid && s2_free;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_instr      <= '0;
      s1_err_align  <= 1'b0;
      s1_err_region <= 1'b0;
    end else begin
      // A new accept always refills S1; otherwise S1 empties once it advances.
      if (in_accept) begin
        s1_valid      <= 1'b1;
        s1_instr      <= instr_d;
        s1_err_align  <= align_err_d;
        s1_err_region <= region_err_d;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage-2 / output register: out_* come straight from these flops and
  // hold while out_valid && !out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_instr      <= '0;
      out_err_align  <= 1'b0;
      out_err_region <= 1'b0;
    end else begin
      if (s1_adv) begin
        out_valid      <= 1'b1;
        out_instr      <= s1_instr;
        out_err_align  <= s1_err_align;
        out_err_region <= s1_err_region;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Saturating count of delivered erroneous words
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (out_fire && (out_err_align || out_err_region)
                 && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_jump_instr_encoder.sv
module tb_jump_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_link;
  logic [31:0] in_pc;
  logic [31:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err_align;
  logic        out_err_region;
  logic [7:0]  err_count;

  // Narrow-counter instance sharing the same stimulus
  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_instr2;
  logic        out_err_align2;
  logic        out_err_region2;
  logic [1:0]  err_count2;

  always #5 clk = ~clk;

  jump_instr_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_link(in_link),
    .in_pc(in_pc), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err_align(out_err_align), .out_err_region(out_err_region),
    .err_count(err_count)
  );

  jump_instr_encoder #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2), .in_link(in_link),
    .in_pc(in_pc), .in_target(in_target),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_err_align(out_err_align2), .out_err_region(out_err_region2),
    .err_count(err_count2)
  );

  typedef struct {
    logic        link;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] instr;
    logic        al;
    logic        rg;
  } vec_t;

  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e8;
    int e2;
    int sent;
    int got;
    logic acc;
    logic hand;
    logic [31:0] pc4;

    vecs[0] = '{1'b0, 32'h0040_0000, 32'h0040_0100, 32'h0810_0040, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h0040_0000, 32'h0040_0100, 32'h0C10_0040, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h0FFF_FFFC, 32'h0FFF_0000, 32'h0BFF_C000, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0040, 32'h0800_0010, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h0040_0000, 32'h0040_0102, 32'h0810_0040, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 32'h0FFF_FFFC, 32'h0000_0006, 32'h0800_0001, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 32'h3000_0000, 32'h3ABC_DEF0, 32'h0EAF_37BC, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_link   = 1'b0;
    in_pc     = '0;
    in_target = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst out_valid", out_valid, 0);
    check("rst out_instr", out_instr, 0);
    check("rst err_align", out_err_align, 0);
    check("rst err_region", out_err_region, 0);
    check("rst err_count", err_count, 0);
    check("rst err_count2", err_count2, 0);
    rst_n = 1'b1;
    #1;
    check("rst in_ready", in_ready, 1);

    // Single-word vectors: latency, encoding, flags, counter
    e8 = 0;
    e2 = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid  = 1'b1;
      in_link   = vecs[i].link;
      in_pc     = vecs[i].pc;
      in_target = vecs[i].tgt;
      #1;
      check("vec in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("vec valid early", out_valid, 0);
      tick();
      check("vec out_valid", out_valid, 1);
      check("vec out_instr", out_instr, vecs[i].instr);
      check("vec err_align", out_err_align, vecs[i].al);
      check("vec err_region", out_err_region, vecs[i].rg);
      if (!vecs[i].al && !vecs[i].rg) begin
        pc4 = vecs[i].pc + 32'd4;
        check("vec roundtrip", {pc4[31:28], out_instr[25:0], 2'b00}, vecs[i].tgt);
      end
      if (vecs[i].al || vecs[i].rg) begin
        e8++;
        if (e2 < 3) e2++;
      end
      tick();
      check("vec drained", out_valid, 0);
      check("vec err_count", err_count, 32'(e8));
      check("vec err_count2", err_count2, 32'(e2));
    end

    // Back-to-back JAL words at full rate
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc < 4) begin
        in_valid  = 1'b1;
        in_link   = 1'b1;
        in_pc     = 32'h0040_0000;
        in_target = 32'h0040_0100 + 32'(cyc * 4);
        #1;
        check("b2b in_ready", in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (cyc >= 1 && cyc <= 4) begin
        check("b2b out_valid", out_valid, 1);
        check("b2b out_instr", out_instr, 32'h0C10_0040 + 32'(cyc - 1));
      end else begin
        check("b2b idle", out_valid, 0);
      end
    end

    // Stall: 3 words, consumer blocked for 5 cycles
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      out_ready = (cyc >= 5);
      if (sent < 3) begin
        in_valid  = 1'b1;
        in_link   = 1'b0;
        in_pc     = 32'h0040_0000;
        in_target = 32'h0040_0200 + 32'(sent * 4);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc <= 5)
        check("stall in_ready", in_ready, (cyc >= 2 && cyc <= 4) ? 32'd0 : 32'd1);
      if (cyc >= 2 && cyc <= 4) begin
        check("stall hold valid", out_valid, 1);
        check("stall hold instr", out_instr, 32'h0810_0080);
      end
      acc  = in_valid && in_ready;
      hand = out_valid && out_ready;
      if (hand) begin
        if (got < 3) check("stall order", out_instr, 32'h0810_0080 + 32'(got));
        else         check("stall extra word", out_valid, 0);
        got++;
      end
      tick();
      if (acc) sent++;
    end
    check("stall delivered", 32'(got), 3);
    check("stall idle", out_valid, 0);

    // Reset with two erroneous words in flight
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid  = 1'b1;
      in_link   = 1'b0;
      in_pc     = 32'h0040_0000;
      in_target = 32'h0040_0103;
      tick();
    end
    in_valid = 1'b0;
    check("pre-rst valid", out_valid, 1);
    check("pre-rst align", out_err_align, 1);
    check("pre-rst in_ready", in_ready, 0);
    rst_n = 1'b0;
    tick();
    check("mid-rst out_valid", out_valid, 0);
    check("mid-rst out_instr", out_instr, 0);
    check("mid-rst err_align", out_err_align, 0);
    check("mid-rst err_region", out_err_region, 0);
    check("mid-rst err_count", err_count, 0);
    check("mid-rst err_count2", err_count2, 0);
    check("mid-rst in_ready", in_ready, 1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post-rst no stale", out_valid, 0);
    end

    // Counter saturation: 5 erroneous words
    for (int k = 0; k < 5; k++) begin
      in_valid  = 1'b1;
      in_link   = 1'b0;
      in_pc     = 32'h0040_0000;
      in_target = 32'h0040_0101;
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("sat err_count", err_count, 5);
    check("sat err_count2", err_count2, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
